// File: rtl/reset_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// reset_sequencer: holds STAGES reset domains, then releases them in order,
// each after its ready acknowledge plus a gap; soft restart and timeout.
// Revision: 1.0
// ----------------------------------------------------------------------------
module reset_sequencer #(
    parameter int STAGES        = 4,
    parameter int HOLD_TICKS    = 16,
    parameter int GAP_TICKS     = 4,
    parameter int TIMEOUT_TICKS = 1024,
    parameter int CNT_W         = 16,
    localparam int IDX_W        = (STAGES > 1) ? $clog2(STAGES) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              soft_rst_req,
    input  logic [STAGES-1:0] stage_ready,
    output logic [STAGES-1:0] stage_rst,
    output logic [IDX_W-1:0]  stage_idx,
    output logic              seq_busy,
    output logic              seq_done,
    output logic              timeout_err,
    output logic              ready_lost
);

    typedef enum logic [1:0] {
        S_HOLD     = 2'd0,
        S_WAIT_RDY = 2'd1,
        S_GAP      = 2'd2,
        S_IDLE     = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] c_hold_ticks = CNT_W'(HOLD_TICKS);
    localparam logic [CNT_W-1:0] c_gap_last   = CNT_W'(GAP_TICKS - 1);
    localparam logic [CNT_W-1:0] c_tmo_last   = CNT_W'(TIMEOUT_TICKS - 1);
    localparam logic [IDX_W-1:0] c_last_idx   = IDX_W'(STAGES - 1);

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic [IDX_W-1:0]  idx_next_d;
    logic [STAGES-1:0] stage_rst_q;
    logic [IDX_W-1:0]  stage_idx_q;
    logic              seq_busy_q;
    logic              seq_done_q;
    logic              timeout_err_q;
    logic              ready_lost_q;

    // Saturating increment so a stalled counter can never wrap back to zero.
    assign cnt_d      = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
    assign idx_next_d = stage_idx_q + 1'b1;

    always_ff @(posedge clk) begin
        // A soft restart lands in exactly the same state as a hard reset.
        if (reset || soft_rst_req) begin
            state_q       <= S_HOLD;
            cnt_q         <= '0;
            stage_rst_q   <= '1;
            stage_idx_q   <= '0;
            seq_busy_q    <= 1'b1;
            seq_done_q    <= 1'b0;
            timeout_err_q <= 1'b0;
            ready_lost_q  <= 1'b0;
        end else begin
            seq_done_q   <= 1'b0;
            ready_lost_q <= 1'b0;
            case (state_q)
                S_HOLD: begin
                    if (cnt_q >= c_hold_ticks) begin
                        stage_rst_q[0] <= 1'b0;
                        stage_idx_q    <= '0;
                        cnt_q          <= '0;
                        state_q        <= S_WAIT_RDY;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                S_WAIT_RDY: begin
                    if (stage_ready[stage_idx_q]) begin
                        cnt_q   <= '0;
                        state_q <= S_GAP;
                    end else if (cnt_q >= c_tmo_last) begin
                        timeout_err_q <= 1'b1;
                        stage_rst_q   <= '1;
                        stage_idx_q   <= '0;
                        cnt_q         <= '0;
                        state_q       <= S_HOLD;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                S_GAP: begin
                    if (cnt_q >= c_gap_last) begin
                        cnt_q <= '0;
                        if (stage_idx_q == c_last_idx) begin
                            seq_done_q <= 1'b1;
                            seq_busy_q <= 1'b0;
                            state_q    <= S_IDLE;
                        end else begin
                            stage_rst_q[idx_next_d] <= 1'b0;
                            stage_idx_q             <= idx_next_d;
                            state_q                 <= S_WAIT_RDY;
                        end
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                S_IDLE: begin
                    if (!(&stage_ready)) begin
                        ready_lost_q <= 1'b1;
                        stage_rst_q  <= '1;
                        stage_idx_q  <= '0;
                        cnt_q        <= '0;
                        seq_busy_q   <= 1'b1;
                        state_q      <= S_HOLD;
                    end
                end
                default: state_q <= S_HOLD;
            endcase
        end
    end

    assign stage_rst   = stage_rst_q;
    assign stage_idx   = stage_idx_q;
    assign seq_busy    = seq_busy_q;
    assign seq_done    = seq_done_q;
    assign timeout_err = timeout_err_q;
    assign ready_lost  = ready_lost_q;

endmodule
`default_nettype wire
